// File: rtl/bsg_fifo_cmd_sequencer_if.sv
// Request/command bundle between the read/write requesters, the sequencer and the command FIFO.
// The sequencer connects through the slave modport; requesters and FIFO sit on the master side.
interface bsg_fifo_cmd_sequencer_if;
    localparam int unsigned addr_w_lp = 27;
    localparam int unsigned cmd_w_lp  = 26;

    logic                 rd_v_i;
    logic [addr_w_lp-1:0] rd_addr_i;
    logic                 rd_yumi_o;
    logic                 wr_v_i;
    logic [addr_w_lp-1:0] wr_addr_i;
    logic                 wr_yumi_o;
    logic                 cmd_v_o;
    logic [cmd_w_lp-1:0]  cmd_data_o;
    logic                 cmd_ready_i;
    logic                 init_done_o;

    modport slave (
        input  rd_v_i, rd_addr_i, wr_v_i, wr_addr_i, cmd_ready_i,
        output rd_yumi_o, wr_yumi_o, cmd_v_o, cmd_data_o, init_done_o
    );

    modport master (
        output rd_v_i, rd_addr_i, wr_v_i, wr_addr_i, cmd_ready_i,
        input  rd_yumi_o, wr_yumi_o, cmd_v_o, cmd_data_o, init_done_o
    );
endinterface

// File: rtl/bsg_fifo_cmd_sequencer.sv
// DDR-style command sequencer: LMR after reset, round-robin RD/WR arbitration, per-bank open-row tracking.
// Define BSG_FIFO_CMD_SEQUENCER_CLOSE_PAGE_EN for close-page operation (auto-precharge on every RD/WR).
module bsg_fifo_cmd_sequencer #(
    parameter int unsigned burst_len_code_p = 3,
    parameter int unsigned cas_latency_p    = 3,
    parameter int unsigned trcd_p           = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    bsg_fifo_cmd_sequencer_if.slave bus
);
    localparam int unsigned bank_w_lp = 2;
    localparam int unsigned row_w_lp  = 14;
    localparam int unsigned col_w_lp  = 11;
    localparam int unsigned banks_lp  = 4;
    localparam int unsigned cmd_w_lp  = 26;
    localparam int unsigned cnt_w_lp  = (trcd_p > 1) ? $clog2(trcd_p) : 1;

`ifdef BSG_FIFO_CMD_SEQUENCER_CLOSE_PAGE_EN
    localparam logic close_page_lp = 1'b1;
`else
    localparam logic close_page_lp = 1'b0;
`endif

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] code_lmr_lp = 4'b0000;
    localparam logic [3:0] code_act_lp = 4'b0011;
    localparam logic [3:0] code_rd_lp  = 4'b0101;
    localparam logic [3:0] code_wr_lp  = 4'b0100;
    localparam logic [3:0] code_pre_lp = 4'b0010;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_PRE, S_ACT, S_WAIT, S_RW
    } state_e;

    state_e                               state_q, state_d;
    logic                                 grant_wr_q, grant_wr_d;
    logic                                 last_wr_q, last_wr_d;
    logic [bank_w_lp-1:0]                 bank_q, bank_d;
    logic [row_w_lp-1:0]                  row_q, row_d;
    logic [col_w_lp-1:0]                  col_q, col_d;
    logic [cnt_w_lp-1:0]                  cnt_q, cnt_d;
    logic [banks_lp-1:0]                  open_v_q, open_v_d;
    logic [banks_lp-1:0][row_w_lp-1:0]    open_row_q, open_row_d;
    logic                                 cmd_v_q, cmd_v_d;
    logic [cmd_w_lp-1:0]                  cmd_data_q, cmd_data_d;
    logic                                 init_done_q, init_done_d;

    logic                                 hs;
    logic                                 pick_wr;
    logic [bank_w_lp+row_w_lp+col_w_lp-1:0] req_addr;
    logic [bank_w_lp-1:0]                 req_bank;
    logic [row_w_lp-1:0]                  req_row;

    function automatic logic [cmd_w_lp-1:0] cmd_word(input logic [bank_w_lp-1:0] bank,
                                                     input logic [15:0] addr,
                                                     input logic [3:0] code);
        return {1'b0, bank, addr, 1'b1, code, 1'b1, 1'b0};
    endfunction

    assign hs = cmd_v_q & bus.cmd_ready_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_INIT;
            grant_wr_q  <= 1'b0;
            last_wr_q   <= 1'b1;
            bank_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            cnt_q       <= '0;
            open_v_q    <= '0;
            open_row_q  <= '0;
            cmd_v_q     <= 1'b0;
            cmd_data_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_wr_q  <= grant_wr_d;
            last_wr_q   <= last_wr_d;
            bank_q      <= bank_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            open_v_q    <= open_v_d;
            open_row_q  <= open_row_d;
            cmd_v_q     <= cmd_v_d;
            cmd_data_q  <= cmd_data_d;
            init_done_q <= init_done_d;
        end
    end

    // Next state, bank tracking, and the command word to present next cycle
    always_comb begin
        state_d     = state_q;
        grant_wr_d  = grant_wr_q;
        last_wr_d   = last_wr_q;
        bank_d      = bank_q;
        row_d       = row_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        open_v_d    = open_v_q;
        open_row_d  = open_row_q;
        init_done_d = init_done_q;
        cmd_v_d     = 1'b0;
        cmd_data_d  = cmd_data_q;

        pick_wr  = bus.wr_v_i & (~bus.rd_v_i | ~last_wr_q);
        req_addr = pick_wr ? bus.wr_addr_i : bus.rd_addr_i;
        req_bank = req_addr[26:25];
        req_row  = req_addr[24:11];

        case (state_q)
            S_INIT: begin
                if (hs) begin
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.rd_v_i | bus.wr_v_i) begin
                    grant_wr_d = pick_wr;
                    bank_d     = req_bank;
                    row_d      = req_row;
                    col_d      = req_addr[10:0];
                    if (open_v_q[req_bank] && (open_row_q[req_bank] == req_row)) begin
                        state_d = S_RW;
                    end else if (open_v_q[req_bank]) begin
                        state_d = S_PRE;
                    end else begin
                        state_d = S_ACT;
                    end
                end
            end
            S_PRE: begin
                if (hs) begin
                    open_v_d[bank_q] = 1'b0;
                    state_d          = S_ACT;
                end
            end
            S_ACT: begin
                if (hs) begin
                    open_v_d[bank_q]   = 1'b1;
                    open_row_d[bank_q] = row_q;
                    if (trcd_p <= 1) begin
                        state_d = S_RW;
                    end else begin
                        cnt_d   = cnt_w_lp'(trcd_p - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= cnt_w_lp'(1)) begin
                    cnt_d   = '0;
                    state_d = S_RW;
                end else begin
                    cnt_d = cnt_q - cnt_w_lp'(1);
                end
            end
            S_RW: begin
                if (hs) begin
                    last_wr_d = grant_wr_q;
                    if (close_page_lp) begin
                        open_v_d[bank_q] = 1'b0;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase

        case (state_d)
            S_INIT: begin
                cmd_v_d    = 1'b1;
                cmd_data_d = cmd_word('0, {9'd0, 3'(cas_latency_p), 1'b0, 3'(burst_len_code_p)},
                                      code_lmr_lp);
            end
            S_PRE: begin
                cmd_v_d    = 1'b1;
                cmd_data_d = cmd_word(bank_d, 16'h0000, code_pre_lp);
            end
            S_ACT: begin
                cmd_v_d    = 1'b1;
                cmd_data_d = cmd_word(bank_d, {2'b00, row_d}, code_act_lp);
            end
            S_RW: begin
                cmd_v_d    = 1'b1;
                cmd_data_d = cmd_word(bank_d, {4'b0000, col_d[10], close_page_lp, col_d[9:0]},
                                      grant_wr_d ? code_wr_lp : code_rd_lp);
            end
            default: cmd_v_d = 1'b0;
        endcase
    end

    // Consumption strobes fire in the RD/WR handshake cycle; a reset in flight never acknowledges
    assign bus.rd_yumi_o   = (state_q == S_RW) & hs & ~grant_wr_q & ~reset_i;
    assign bus.wr_yumi_o   = (state_q == S_RW) & hs &  grant_wr_q & ~reset_i;
    assign bus.cmd_v_o     = cmd_v_q;
    assign bus.cmd_data_o  = cmd_data_q;
    assign bus.init_done_o = init_done_q;

endmodule

// File: tb/tb_bsg_fifo_cmd_sequencer.sv
// Bench for bsg_fifo_cmd_sequencer: request-level command model plus directed scenarios.
module tb_bsg_fifo_cmd_sequencer;
    localparam int unsigned TRCD = 2;
    localparam int unsigned BL   = 3;
    localparam int unsigned CL   = 3;
`ifdef BSG_FIFO_CMD_SEQUENCER_CLOSE_PAGE_EN
    localparam logic CP = 1'b1;
`else
    localparam logic CP = 1'b0;
`endif
    localparam int K_LMR = 0, K_PRE = 1, K_ACT = 2, K_RD = 3, K_WR = 4;

    typedef struct {
        logic [25:0] data;
        int          kind;
    } exp_t;

    logic clk = 1'b0;
    logic reset_i;
    bsg_fifo_cmd_sequencer_if bus_if();

    bsg_fifo_cmd_sequencer #(
        .burst_len_code_p(BL),
        .cas_latency_p   (CL),
        .trcd_p          (TRCD)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester queues, expected command stream and observation logs
    logic [26:0] rd_q[$];
    logic [26:0] wr_q[$];
    exp_t        exp_q[$];
    logic [25:0] seen_q[$];
    int          grant_log[$];

    // Model state
    logic        m_open_v[4];
    logic [13:0] m_open_row[4];
    logic        m_last_wr;

    // Stimulus / checker state
    int   cyc = 0;
    int   rst_cycles = 0;
    int   stall_cnt = 0;
    int   act_cyc = 0;
    logic rst_at_edge = 1'b0;
    logic pend_rd = 1'b0, pend_wr = 1'b0;
    logic rst_arm = 1'b0, stall_arm = 1'b0, toggle_ready = 1'b0;
    logic hs_act_prev = 1'b0, gap_pending = 1'b0, prev_stall = 1'b0, init_exp = 1'b0;
    logic [25:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] enc(input int kind, input logic [1:0] bank, input logic [15:0] addr);
        logic [3:0] c;
        case (kind)
            K_LMR:   c = 4'b0000;
            K_ACT:   c = 4'b0011;
            K_RD:    c = 4'b0101;
            K_WR:    c = 4'b0100;
            default: c = 4'b0010;
        endcase
        return {1'b0, bank, addr, 1'b1, c, 1'b1, 1'b0};
    endfunction

    task automatic push(input int kind, input logic [1:0] bank, input logic [15:0] addr);
        exp_t e;
        e.data = enc(kind, bank, addr);
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    // Expand the pending requests into commands: alternate on ties, PRE/ACT only when the row is not open
    task automatic plan();
        logic [26:0] r[$];
        logic [26:0] w[$];
        logic [26:0] a;
        logic        pw;
        logic [1:0]  b;
        logic [13:0] row;
        logic [10:0] col;
        r = rd_q;
        w = wr_q;
        while (r.size() != 0 || w.size() != 0) begin
            pw = (r.size() != 0 && w.size() != 0) ? !m_last_wr : (w.size() != 0);
            if (pw) begin a = w[0]; w.delete(0); end
            else    begin a = r[0]; r.delete(0); end
            m_last_wr = pw;
            {b, row, col} = a;
            if (CP || !(m_open_v[b] && m_open_row[b] == row)) begin
                if (m_open_v[b]) push(K_PRE, b, 16'h0000);
                push(K_ACT, b, {2'b00, row});
                m_open_v[b]   = 1'b1;
                m_open_row[b] = row;
            end
            push(pw ? K_WR : K_RD, b, {4'b0000, col[10], CP, col[9:0]});
            if (CP) m_open_v[b] = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            m_open_v[i]   = 1'b0;
            m_open_row[i] = '0;
        end
        m_last_wr = 1'b1;
        push(K_LMR, 2'd0, {9'd0, 3'(CL), 1'b0, 3'(BL)});
        plan();
    endtask

    function automatic logic [25:0] seen_at(input int i);
        return (i < seen_q.size()) ? seen_q[i] : 26'h3ffffff;
    endfunction

    function automatic int grant_at(input int i);
        return (i < grant_log.size()) ? grant_log[i] : -1;
    endfunction

    // Drive at negedge, then compare outputs against the model once they have settled
    always @(negedge clk) begin
        logic hs;
        exp_t e;
        rst_at_edge = reset_i;
        cyc++;
        if (pend_rd && rd_q.size() != 0) rd_q.delete(0);
        if (pend_wr && wr_q.size() != 0) wr_q.delete(0);
        pend_rd = 1'b0;
        pend_wr = 1'b0;
        if (rst_arm && hs_act_prev && !bus_if.cmd_v_o) begin
            rst_arm    = 1'b0;
            rst_cycles = 1;
            model_reset();
        end
        hs_act_prev = 1'b0;
        if (rst_cycles > 0) begin reset_i = 1'b1; rst_cycles--; end
        else reset_i = 1'b0;
        if (stall_arm && bus_if.cmd_v_o && bus_if.cmd_data_o[5:2] == 4'b0011 && stall_cnt < 5) begin
            bus_if.cmd_ready_i = 1'b0;
            stall_cnt++;
        end else if (toggle_ready) begin
            bus_if.cmd_ready_i = (cyc % 3) != 0;
        end else begin
            bus_if.cmd_ready_i = 1'b1;
        end
        bus_if.rd_v_i    = rd_q.size() != 0;
        bus_if.rd_addr_i = (rd_q.size() != 0) ? rd_q[0] : '0;
        bus_if.wr_v_i    = wr_q.size() != 0;
        bus_if.wr_addr_i = (wr_q.size() != 0) ? wr_q[0] : '0;
        #1;
        if (rst_at_edge) begin
            check("rst_cmd_v", 32'(bus_if.cmd_v_o), 0);
            check("rst_cmd_data", 32'(bus_if.cmd_data_o), 0);
            check("rst_init_done", 32'(bus_if.init_done_o), 0);
            check("rst_rd_yumi", 32'(bus_if.rd_yumi_o), 0);
            check("rst_wr_yumi", 32'(bus_if.wr_yumi_o), 0);
        end
        if (reset_i) begin
            gap_pending = 1'b0;
            prev_stall  = 1'b0;
            init_exp    = 1'b0;
        end else begin
            check("init_done", 32'(bus_if.init_done_o), 32'(init_exp));
            if (prev_stall) begin
                check("stall_v_held", 32'(bus_if.cmd_v_o), 1);
                check("stall_data_held", 32'(bus_if.cmd_data_o), 32'(prev_data));
            end
            if (gap_pending && bus_if.cmd_v_o) begin
                check("act_to_rw_gap_ok", 32'(cyc - act_cyc >= TRCD), 1);
                gap_pending = 1'b0;
            end
            hs = bus_if.cmd_v_o & bus_if.cmd_ready_i;
            if (hs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_cmd: got 0x%0h, expected no command", bus_if.cmd_data_o);
                end else begin
                    n_checks--;
                    e = exp_q.pop_front();
                    check("cmd_data", 32'(bus_if.cmd_data_o), 32'(e.data));
                    check("rd_yumi_hs", 32'(bus_if.rd_yumi_o), 32'(e.kind == K_RD));
                    check("wr_yumi_hs", 32'(bus_if.wr_yumi_o), 32'(e.kind == K_WR));
                    if (e.kind == K_ACT) begin
                        gap_pending = 1'b1;
                        act_cyc     = cyc;
                        hs_act_prev = 1'b1;
                    end
                    if (e.kind == K_LMR) init_exp = 1'b1;
                end
                seen_q.push_back(bus_if.cmd_data_o);
                if (bus_if.rd_yumi_o) grant_log.push_back(0);
                if (bus_if.wr_yumi_o) grant_log.push_back(1);
                pend_rd = bus_if.rd_yumi_o;
                pend_wr = bus_if.wr_yumi_o;
            end else begin
                check("rd_yumi_idle", 32'(bus_if.rd_yumi_o), 0);
                check("wr_yumi_idle", 32'(bus_if.wr_yumi_o), 0);
            end
            prev_stall = bus_if.cmd_v_o & ~bus_if.cmd_ready_i;
            prev_data  = bus_if.cmd_data_o;
        end
    end

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || rd_q.size() != 0 || wr_q.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        n_checks++;
        if (n >= 400) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending commands, expected 0", name, exp_q.size());
        end
        repeat (4) @(posedge clk);
        #2;
    endtask

    initial begin
        int p;
        int g;
        reset_i            = 1'b1;
        bus_if.cmd_ready_i = 1'b1;
        bus_if.rd_v_i      = 1'b0;
        bus_if.rd_addr_i   = '0;
        bus_if.wr_v_i      = 1'b0;
        bus_if.wr_addr_i   = '0;
        rst_cycles         = 2;
        model_reset();

        // Load-mode word after reset
        drain("init");
        check("lmr_word", 32'(seen_at(0)), 32'({3'd0, 16'h0033, 7'b1000010}));
        check("init_done_up", 32'(bus_if.init_done_o), 1);

        // Closed bank: ACT, gap, RD
        @(posedge clk);
        p = seen_q.size();
        g = grant_log.size();
        rd_q.push_back({2'd1, 14'h0123, 11'h405});
        plan();
        drain("first_read");
        check("p2_act", 32'(seen_at(p)), 32'({3'd1, 16'h0123, 7'b1001110}));
        check("p2_rd", 32'(seen_at(p + 1)), 32'({3'd1, CP ? 16'h0C05 : 16'h0805, 7'b1010110}));
        check("p2_grant", grant_at(g), 0);

        // Row hit, then row miss in the same bank
        @(posedge clk);
        p = seen_q.size();
        rd_q.push_back({2'd1, 14'h0123, 11'h405});
        rd_q.push_back({2'd1, 14'h0200, 11'h005});
        plan();
        drain("hit_miss");
`ifdef BSG_FIFO_CMD_SEQUENCER_CLOSE_PAGE_EN
        check("p3_act0", 32'(seen_at(p)), 32'({3'd1, 16'h0123, 7'b1001110}));
        check("p3_rd0", 32'(seen_at(p + 1)), 32'({3'd1, 16'h0C05, 7'b1010110}));
        check("p3_act1", 32'(seen_at(p + 2)), 32'({3'd1, 16'h0200, 7'b1001110}));
        check("p3_rd1", 32'(seen_at(p + 3)), 32'({3'd1, 16'h0405, 7'b1010110}));
`else
        check("p3_rd_hit", 32'(seen_at(p)), 32'({3'd1, 16'h0805, 7'b1010110}));
        check("p3_pre", 32'(seen_at(p + 1)), 32'({3'd1, 16'h0000, 7'b1001010}));
        check("p3_act", 32'(seen_at(p + 2)), 32'({3'd1, 16'h0200, 7'b1001110}));
        check("p3_rd", 32'(seen_at(p + 3)), 32'({3'd1, 16'h0005, 7'b1010110}));
`endif

        // Both requesters valid with a stuttering FIFO; the last grant was a read, so write leads
        @(posedge clk);
        toggle_ready = 1'b1;
        g = grant_log.size();
        rd_q.push_back({2'd2, 14'd7, 11'd1});
        rd_q.push_back({2'd3, 14'd9, 11'd2});
        wr_q.push_back({2'd2, 14'd7, 11'd3});
        wr_q.push_back({2'd3, 14'd9, 11'd4});
        plan();
        drain("round_robin");
        toggle_ready = 1'b0;
        check("p4_grant0", grant_at(g), 1);
        check("p4_grant1", grant_at(g + 1), 0);
        check("p4_grant2", grant_at(g + 2), 1);
        check("p4_grant3", grant_at(g + 3), 0);

        // Back-pressure on ACT, then reset during the ACT-to-RD gap
        @(posedge clk);
        stall_cnt = 0;
        stall_arm = 1'b1;
        rst_arm   = 1'b1;
        p = seen_q.size();
        rd_q.push_back({2'd0, 14'h3ff, 11'd1});
        plan();
        drain("stall_reset");
        stall_arm = 1'b0;
        check("p5_stall_cycles", stall_cnt, 5);
        check("p5_act_before", 32'(seen_at(p)), 32'({3'd0, 16'h03ff, 7'b1001110}));
        check("p5_lmr", 32'(seen_at(p + 1)), 32'({3'd0, 16'h0033, 7'b1000010}));
        check("p5_act_again", 32'(seen_at(p + 2)), 32'({3'd0, 16'h03ff, 7'b1001110}));
        check("p5_rd", 32'(seen_at(p + 3)), 32'({3'd0, CP ? 16'h0401 : 16'h0001, 7'b1010110}));

        // Two reads to one row after the reset cleared all banks
        @(posedge clk);
        p = seen_q.size();
        rd_q.push_back({2'd2, 14'h0055, 11'h010});
        rd_q.push_back({2'd2, 14'h0055, 11'h010});
        plan();
        drain("same_row");
`ifdef BSG_FIFO_CMD_SEQUENCER_CLOSE_PAGE_EN
        check("p6_act0", 32'(seen_at(p)), 32'({3'd2, 16'h0055, 7'b1001110}));
        check("p6_rd0", 32'(seen_at(p + 1)), 32'({3'd2, 16'h0410, 7'b1010110}));
        check("p6_act1", 32'(seen_at(p + 2)), 32'({3'd2, 16'h0055, 7'b1001110}));
        check("p6_rd1", 32'(seen_at(p + 3)), 32'({3'd2, 16'h0410, 7'b1010110}));
`else
        check("p6_act", 32'(seen_at(p)), 32'({3'd2, 16'h0055, 7'b1001110}));
        check("p6_rd0", 32'(seen_at(p + 1)), 32'({3'd2, 16'h0010, 7'b1010110}));
        check("p6_rd1", 32'(seen_at(p + 2)), 32'({3'd2, 16'h0010, 7'b1010110}));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
